ones_expander: RTL and testbench

Sequential inverse of the 63-bit ones counter. It accepts a 6-bit count N and builds a 63-bit thermometer word with exactly N ones in bits N-1..0, filled one bit per clock. It sits on the producer side of the popcount path: it generates reference vectors whose ones count is known, so feeding its output back into the counter must return N. Input and output each use a valid/ready handshake.

---
 rtl/ones_expander_if.sv | 12 +
 rtl/ones_expander.sv | 77 +++++++
 tb/tb_ones_expander.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ones_expander_if.sv
// ones_expander_if: count-in / word-out valid-ready bus for ones_expander.
interface ones_expander_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  count;
  logic        out_valid;
  logic        out_ready;
  logic [62:0] W;
  logic        busy;
  modport master (output in_valid, count, out_ready, input in_ready, out_valid, W, busy);
  modport slave  (input in_valid, count, out_ready, output in_ready, out_valid, W, busy);
endinterface

// File: rtl/ones_expander.sv
// ones_expander: builds a 63-bit thermometer word with N ones, one bit per clock.
// Optional serial tap of the inserted bits via ONES_EXPANDER_SERIAL_EN.
module ones_expander (
  input  logic clk,
  input  logic rst,
`ifdef ONES_EXPANDER_SERIAL_EN
  output logic sout,
  output logic sout_valid,
`endif
  ones_expander_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t      state_q, state_d;
  logic [62:0] shreg_q, shreg_d;
  logic [5:0]  remain_q, remain_d;
  logic [5:0]  step_q, step_d;
  logic        b;
  assign b = remain_q != 6'd0;
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    remain_d = remain_q;
    step_d   = step_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        remain_d = bus.count;
        step_d   = 6'd0;
        shreg_d  = 63'd0;
        state_d  = FILL;
      end
      FILL: begin
        // always 63 shifts, so the first inserted bit lands at bit 0
        shreg_d  = {b, shreg_q[62:1]};
        remain_d = remain_q - {5'd0, b};
        step_d   = step_q + 6'd1;
        state_d  = step_q == 6'd62 ? DONE : FILL;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= 63'd0;
      remain_q <= 6'd0;
      step_q   <= 6'd0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      remain_q <= remain_d;
      step_q   <= step_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.W         = shreg_q;
`ifdef ONES_EXPANDER_SERIAL_EN
  logic sout_q, sout_d, sout_valid_q, sout_valid_d;
  always_comb begin
    sout_d       = (state_q == FILL) & b;
    sout_valid_d = state_q == FILL;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
    end else begin
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  end
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
`endif
endmodule

// File: tb/tb_ones_expander.sv
// tb_ones_expander: scoreboard bench for ones_expander with a thermometer-code reference model.
module tb_ones_expander;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ones_expander_if ifc ();
`ifdef ONES_EXPANDER_SERIAL_EN
  logic sout, sout_valid;
  ones_expander dut (.clk(clk), .rst(rst), .sout(sout), .sout_valid(sout_valid), .bus(ifc.slave));
`else
  ones_expander dut (.clk(clk), .rst(rst), .bus(ifc.slave));
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [62:0] exp_w[$];
  int exp_n[$];
  int acc_q[$];
  logic rand_ready = 1'b0;
  logic forced_ready = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [62:0] model(int n);
    logic [63:0] t;
    t = (64'd1 << n) - 64'd1;
    return t[62:0];
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask
  initial begin
    ifc.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 ifc.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
    end
  end
  logic prev_ov = 1'b0;
  logic chk_idle = 1'b0;
  logic [62:0] held_w;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov  <= 1'b0;
      chk_idle <= 1'b0;
    end else begin
      if (chk_idle) begin
        check("in_ready_after_handshake", {63'd0, ifc.in_ready}, 64'd1);
        check("out_valid_dropped", {63'd0, ifc.out_valid}, 64'd0);
      end
      chk_idle <= 1'b0;
      if (ifc.out_valid && !prev_ov) begin
        held_w = ifc.W;
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got W=%h expected none", ifc.W);
        end else check("latency_cycles", 64'(cyc), 64'(acc_q.pop_front() + 63));
      end
      if (ifc.out_valid && prev_ov) check("W_stable", {1'b0, ifc.W}, {1'b0, held_w});
      if (ifc.out_valid) check("in_ready_excl", {63'd0, ifc.in_ready}, 64'd0);
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %h expected none", ifc.W);
        end else begin
          check("W", {1'b0, ifc.W}, {1'b0, exp_w.pop_front()});
          check("popcount", 64'($countones(ifc.W)), 64'(exp_n.pop_front()));
        end
        chk_idle <= 1'b1;
      end
      prev_ov <= ifc.out_valid;
    end
  end
`ifdef ONES_EXPANDER_SERIAL_EN
  logic [62:0] ser = '0;
  int ser_n = 0;
  always @(negedge clk) begin
    if (rst) begin
      ser_n = 0;
      ser = '0;
    end else begin
      if (sout_valid) begin
        if (ser_n < 63) ser[ser_n] = sout;
        ser_n++;
      end else check("sout_idle", {63'd0, sout}, 64'd0);
      if (ifc.out_valid && !prev_ov) begin
        check("sout_valid_len", 64'(ser_n), 64'd63);
        if (exp_w.size() != 0) check("sout_stream", {1'b0, ser}, {1'b0, exp_w[0]});
        ser_n = 0;
        ser = '0;
      end
    end
  end
`endif
  task automatic send(int n);
    int t = 0;
    while (!ifc.in_ready && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    ifc.in_valid = 1'b1;
    ifc.count = 6'(n);
    exp_w.push_back(model(n));
    exp_n.push_back(n);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask
  task automatic wait_empty();
    int t = 0;
    while (exp_w.size() != 0 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_w.size());
      exp_w.delete(); exp_n.delete(); acc_q.delete();
    end
  endtask
  initial begin
    ifc.in_valid = 1'b0;
    ifc.count = 6'd0;
    #2;
    check("rst_W", {1'b0, ifc.W}, 64'd0);
    check("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    check("rst_busy", {63'd0, ifc.busy}, 64'd0);
    check("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    forced_ready = 1'b1;
    @(posedge clk); #1;
    send(0);
    check("busy_in_fill", {63'd0, ifc.busy}, 64'd1);
    wait_empty();
    send(63);
    wait_empty();
    forced_ready = 1'b0;
    @(posedge clk); #1;
    send(5);
    begin
      int t = 0;
      while (!ifc.out_valid && t < 200) begin @(posedge clk); #1; t++; end
    end
    repeat (10) begin
      check("hold_in_ready", {63'd0, ifc.in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    forced_ready = 1'b1;
    wait_empty();
    send(3);
    repeat (10) @(posedge clk);
    #1 ifc.in_valid = 1'b1; ifc.count = 6'd9;
    repeat (3) @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    wait_empty();
    repeat (4) @(posedge clk);
    check("no_extra_word", {63'd0, ifc.out_valid}, 64'd0);
    #1;
    send(40);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_W", {1'b0, ifc.W}, 64'd0);
    check("abort_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, ifc.in_ready}, 64'd1);
    exp_w.delete(); exp_n.delete(); acc_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(2);
    wait_empty();
    send(4);
    wait_empty();
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(posedge clk);
      #0;
    end
    wait_empty();
    rand_ready = 1'b0;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
